// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, drives a synchronous instruction
// memory and registers the IF/ID boundary with redirect, stall, flush and halt.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              IMEM_ADDR_WIDTH = 5,
  parameter int              COUNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            PCTargetE,
  input  logic                       PCSrcE,
  input  logic                       StallF,
  input  logic                       StallD,
  input  logic                       FlushD,
  input  logic                       HaltF,
  output logic [IMEM_ADDR_WIDTH-1:0] ImemAddr,
  output logic                       ImemEn,
  input  logic [31:0]                ImemRdata,
  output logic [31:0]                InstrD,
  output logic [XLEN-1:0]            PCD,
  output logic [XLEN-1:0]            PCPlus4D,
  output logic                       ValidD,
  output logic [1:0]                 FaultD,
  output logic [COUNT_WIDTH-1:0]     FetchCount
);

  localparam logic [31:0]     NOP  = 32'h0000_0013;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                 state_reg, state_next;
  logic [XLEN-1:0]        pc_reg, pc_next;
  logic [XLEN-1:0]        pc_plus4;
  logic                   issue;
  logic                   mis, oor;
  logic                   load_valid;
  logic [XLEN-1:0]        pcd_reg, pcp4_reg;
  logic                   valid_reg;
  logic [1:0]             fault_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= BOOT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (HaltF && !PCSrcE) state_next = HALT;
      HALT:    if (PCSrcE) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    issue  = (state_reg == RUN) && !StallD && !HaltF;
    ImemEn = issue;
  end

  assign pc_plus4   = pc_reg + FOUR;
  assign mis        = |pc_reg[1:0];
  assign oor        = |pc_reg[XLEN-1:IMEM_ADDR_WIDTH+2];
  assign load_valid = issue && !StallF && !PCSrcE && !FlushD;
  assign ImemAddr   = pc_reg[IMEM_ADDR_WIDTH+1:2];

  // Redirect is honoured in every state except BOOT, even during a fetch stall.
  always_comb begin
    pc_next = pc_reg;
    if (PCSrcE && state_reg != BOOT) pc_next = PCTargetE;
    else if (issue && !StallF)       pc_next = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_reg <= RESET_PC;
    else        pc_reg <= pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcd_reg   <= '0;
      pcp4_reg  <= '0;
      fault_reg <= '0;
    end else if (!StallD) begin
      pcd_reg   <= pc_reg;
      pcp4_reg  <= pc_plus4;
      fault_reg <= {oor, mis};
    end
  end

  // FlushD clears the valid bit even while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                valid_reg <= 1'b0;
    else if (FlushD || !StallD) valid_reg <= load_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count_reg <= '0;
    else if (load_valid) count_reg <= count_reg + COUNT_WIDTH'(1);
  end

  assign PCD        = pcd_reg;
  assign PCPlus4D   = pcp4_reg;
  assign ValidD     = valid_reg;
  assign FaultD     = fault_reg;
  assign FetchCount = count_reg;
  assign InstrD     = (valid_reg && fault_reg == 2'b00) ? ImemRdata : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model with a local instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        PCSrcE = 1'b0, StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, HaltF = 1'b0;
  logic [4:0]  ImemAddr;
  logic        ImemEn;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD;
  logic [1:0]  FaultD;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:31];
  logic [31:0] rdata_reg = '0;

  // Model state
  logic [31:0] m_pc, m_pcd, m_pcp4, m_count;
  logic        m_valid, m_booted, m_halted;
  logic [1:0]  m_fault;

  always #5 clk = ~clk;

  always @(posedge clk) if (ImemEn) rdata_reg <= mem[ImemAddr];
  assign ImemRdata = rdata_reg;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .HaltF(HaltF),
    .ImemAddr(ImemAddr), .ImemEn(ImemEn), .ImemRdata(ImemRdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FaultD(FaultD), .FetchCount(FetchCount)
  );

  function automatic logic [31:0] exp_instr();
    return (m_valid && m_fault == 2'b00) ? mem[m_pcd[6:2]] : NOP;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pcd = '0; m_pcp4 = '0; m_count = '0;
    m_valid = 1'b0; m_fault = 2'b00; m_booted = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step(input logic pcsrc, input logic [31:0] tgt,
                            input logic sf, input logic sd, input logic fl, input logic hf);
    logic iss, ld1;
    iss = m_booted && !m_halted && !sd && !hf;
    ld1 = iss && !sf && !pcsrc && !fl;
    if (!sd) begin
      m_pcd   = m_pc;
      m_pcp4  = m_pc + 32'd4;
      m_fault = {(m_pc >> 7) != 0, m_pc[1:0] != 2'b00};
    end
    if (!sd || fl) m_valid = ld1;
    if (ld1) m_count = m_count + 1;
    if (m_booted && pcsrc)  m_pc = tgt;
    else if (iss && !sf)    m_pc = m_pc + 32'd4;
    if (!m_booted)          m_booted = 1'b1;
    else if (!m_halted)     begin if (hf && !pcsrc) m_halted = 1'b1; end
    else if (pcsrc)         m_halted = 1'b0;
  endtask

  task automatic drive_cycle(input logic pcsrc, input logic [31:0] tgt,
                             input logic sf, input logic sd, input logic fl, input logic hf);
    PCSrcE = pcsrc; PCTargetE = tgt; StallF = sf; StallD = sd; FlushD = fl; HaltF = hf;
    @(posedge clk);
    model_step(pcsrc, tgt, sf, sd, fl, hf);
    #1;
  endtask

  task automatic do_reset();
    PCSrcE = 0; PCTargetE = '0; StallF = 0; StallD = 0; FlushD = 0; HaltF = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || FaultD !== 2'b00 ||
        FetchCount !== 32'h0 || InstrD !== NOP || ImemEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: V=%b PCD=%h P4=%h F=%b cnt=%0d I=%h en=%b required all zero, I=NOP",
               ValidD, PCD, PCPlus4D, FaultD, FetchCount, InstrD, ImemEn);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_boot_sequence();
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b0) begin
      tests_failed++; $display("FAIL boot_edge1_valid: got %b required 0", ValidD);
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (ValidD !== 1'b1 || PCD !== 32'(4*k) || PCPlus4D !== 32'(4*k+4) ||
          InstrD !== mem[k] || ImemEn !== 1'b1) begin
        tests_failed++;
        $display("FAIL boot_fetch_%0d: V=%b PCD=%h P4=%h I=%h en=%b required V=1 PCD=%h I=%h en=1",
                 k, ValidD, PCD, PCPlus4D, InstrD, ImemEn, 32'(4*k), mem[k]);
      end
    end
    tests_run++;
    if (FetchCount !== 32'd4) begin
      tests_failed++; $display("FAIL boot_count: got %0d required 4", FetchCount);
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 1, 1, 0, 0);
      tests_run++;
      if (ValidD !== 1'b1 || PCD !== 32'h4 || InstrD !== mem[1] || ImemEn !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: V=%b PCD=%h I=%h en=%b required V=1 PCD=4 I=%h en=0",
                 k, ValidD, PCD, InstrD, ImemEn, mem[1]);
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b1 || PCD !== 32'h8 || InstrD !== mem[2]) begin
      tests_failed++;
      $display("FAIL stall_release: V=%b PCD=%h I=%h required V=1 PCD=8 I=%h", ValidD, PCD, InstrD, mem[2]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(1, 32'h40, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b0 || FetchCount !== 32'd2) begin
      tests_failed++;
      $display("FAIL redirect_bubble: V=%b cnt=%0d required V=0 cnt=2", ValidD, FetchCount);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b1 || PCD !== 32'h40 || InstrD !== mem[16] || FetchCount !== 32'd3) begin
      tests_failed++;
      $display("FAIL redirect_target: V=%b PCD=%h I=%h cnt=%0d required V=1 PCD=40 I=%h cnt=3",
               ValidD, PCD, InstrD, FetchCount, mem[16]);
    end
  endtask

  task automatic test_fault();
    logic [31:0] tgts [3];
    logic [1:0]  faults [3];
    tgts = '{32'h42, 32'h80, 32'hFFFF_FFFC};
    faults = '{2'b01, 2'b10, 2'b10};
    do_reset();
    repeat (2) drive_cycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, tgts[k], 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (ValidD !== 1'b1 || PCD !== tgts[k] || PCPlus4D !== tgts[k] + 32'd4 ||
          FaultD !== faults[k] || InstrD !== NOP) begin
        tests_failed++;
        $display("FAIL fault_%0d: V=%b PCD=%h P4=%h F=%b I=%h required V=1 PCD=%h F=%b I=NOP",
                 k, ValidD, PCD, PCPlus4D, FaultD, InstrD, tgts[k], faults[k]);
      end
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b1 || PCD !== 32'h0 || FaultD !== 2'b00 || InstrD !== mem[0]) begin
      tests_failed++;
      $display("FAIL pc_wrap: V=%b PCD=%h F=%b I=%h required V=1 PCD=0 F=00 I=%h",
               ValidD, PCD, FaultD, InstrD, mem[0]);
    end
  endtask

  task automatic test_halt_flush();
    do_reset();
    repeat (2) drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    tests_run++;
    if (ValidD !== 1'b0 || ImemEn !== 1'b0) begin
      tests_failed++; $display("FAIL halt_enter: V=%b en=%b required 0 0", ValidD, ImemEn);
    end
    repeat (2) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (ValidD !== 1'b0 || ImemEn !== 1'b0) begin
        tests_failed++; $display("FAIL halt_hold: V=%b en=%b required 0 0", ValidD, ImemEn);
      end
    end
    drive_cycle(1, 32'h10, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b1 || PCD !== 32'h10 || InstrD !== mem[4]) begin
      tests_failed++;
      $display("FAIL halt_resume: V=%b PCD=%h I=%h required V=1 PCD=10 I=%h", ValidD, PCD, InstrD, mem[4]);
    end
    drive_cycle(0, 0, 0, 1, 1, 0);
    tests_run++;
    if (ValidD !== 1'b0 || PCD !== 32'h10 || InstrD !== NOP) begin
      tests_failed++;
      $display("FAIL flush_over_stall: V=%b PCD=%h I=%h required V=0 PCD=10 I=NOP", ValidD, PCD, InstrD);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) drive_cycle(0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || FetchCount !== 32'h0 ||
        InstrD !== NOP || ImemEn !== 1'b0 || FaultD !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: V=%b PCD=%h P4=%h cnt=%0d I=%h en=%b F=%b required reset values",
               ValidD, PCD, PCPlus4D, FetchCount, InstrD, ImemEn, FaultD);
    end
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== mem[0] || FetchCount !== 32'd1) begin
      tests_failed++;
      $display("FAIL async_reset_restart: V=%b PCD=%h I=%h cnt=%0d required V=1 PCD=0 I=%h cnt=1",
               ValidD, PCD, InstrD, FetchCount, mem[0]);
    end
  endtask

  task automatic test_random();
    logic        pcsrc, sf, sd, fl, hf, exp_en;
    logic [31:0] tgt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pcsrc = ($urandom_range(0, 7) == 0);
      sf    = ($urandom_range(0, 5) == 0);
      sd    = ($urandom_range(0, 5) == 0);
      fl    = ($urandom_range(0, 9) == 0);
      hf    = ($urandom_range(0, 15) == 0);
      tgt   = ($urandom_range(0, 5) == 0) ? $urandom : {25'd0, 5'($urandom_range(0, 31)), 2'b00};
      drive_cycle(pcsrc, tgt, sf, sd, fl, hf);
      exp_en = m_booted && !m_halted && !sd && !hf;
      tests_run++;
      if (ValidD !== m_valid || PCD !== m_pcd || PCPlus4D !== m_pcp4 || FaultD !== m_fault ||
          FetchCount !== m_count || InstrD !== exp_instr() || ImemEn !== exp_en ||
          (exp_en && ImemAddr !== m_pc[6:2])) begin
        tests_failed++;
        $display("FAIL random_%0d: V=%b PCD=%h P4=%h F=%b cnt=%0d I=%h en=%b A=%0d required V=%b PCD=%h P4=%h F=%b cnt=%0d I=%h en=%b A=%0d",
                 n, ValidD, PCD, PCPlus4D, FaultD, FetchCount, InstrD, ImemEn, ImemAddr,
                 m_valid, m_pcd, m_pcp4, m_fault, m_count, exp_instr(), exp_en, m_pc[6:2]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    model_reset();
    test_reset();
    test_boot_sequence();
    test_stall();
    test_redirect();
    test_fault();
    test_halt_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the RISC-V pipeline. It holds the PC, drives a synchronous instruction memory through an enable and address port, and registers the IF/ID boundary: PCD, PCPlus4D, ValidD and FaultD. It also handles redirect, stall, flush, halt, fetch-fault detection and a delivered-instruction counter. It sits between the hazard unit and execute-stage branch resolution on one side and the decode stage on the other.

## Interface
- XLEN, 32: PC and instruction-address width.
- RESET_PC, 32'h0: PC loaded on reset.
- IMEM_ADDR_WIDTH, 5: word-address width of instruction memory (2^N words).
- COUNT_WIDTH, 32: width of FetchCount.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- PCTargetE  in  XLEN  redirect target from execute.
- PCSrcE  in  1  redirect request (taken branch or jump).
- StallF  in  1  hold PCF.
- StallD  in  1  hold IF/ID registers.
- FlushD  in  1  turn the IF/ID contents into a bubble.
- HaltF  in  1  stop issuing fetches.
- ImemAddr  out  IMEM_ADDR_WIDTH  word address, PCF[IMEM_ADDR_WIDTH+1:2].
- ImemEn  out  1  memory read enable. The memory registers mem[ImemAddr] into ImemRdata at the edge when this is 1 and holds it otherwise.
- ImemRdata  in  32  registered memory output.
- InstrD  out  32  instruction to decode.
- PCD, PCPlus4D  out  XLEN  PC of InstrD and that PC + 4.
- ValidD  out  1  InstrD is a real instruction.
- FaultD  out  2  bit0 misaligned PC, bit1 PC outside memory.
- FetchCount  out  COUNT_WIDTH  count of valid instructions delivered.

## Operation
- States: BOOT, RUN, HALT.
  - Reset enters BOOT.
  - BOOT -> RUN unconditionally on the first edge. No fetch is issued in BOOT.
  - RUN -> HALT when HaltF=1 and PCSrcE=0.
  - HALT -> RUN on PCSrcE=1.
  - HaltF is ignored outside RUN.
- issue = (state==RUN) & ~StallD & ~HaltF. ImemEn = issue.
- Next PC, evaluated every edge:
  - PCSrcE=1: PCF <= PCTargetE, regardless of StallF or state (except BOOT).
  - Else if issue & ~StallF: PCF <= PCF + 4.
  - Else PCF holds.
- PC arithmetic is modulo 2^XLEN. 32'hFFFFFFFC + 4 = 0.
- Faults are computed from PCF at issue:
  - mis = PCF[1:0] != 0.
  - oor = PCF[XLEN-1:IMEM_ADDR_WIDTH+2] != 0.
- IF/ID registers load only when ~StallD:
  - PCD <= PCF.
  - PCPlus4D <= PCF + 4.
  - FaultD <= {oor, mis}.
  - ValidD <= issue & ~StallF & ~PCSrcE & ~FlushD.
- With StallF=1 and StallD=0, a bubble is inserted: ValidD=0, and the same PCF is re-fetched later.
- FlushD overrides StallD: FlushD=1 forces ValidD <= 0 even when StallD=1. The other IF/ID registers still hold.
- InstrD = 32'h00000013 (NOP) when ValidD=0 or FaultD!=0. Otherwise InstrD = ImemRdata.
- A faulted instruction stays ValidD=1 so decode can raise the exception.
- FetchCount increments by 1 at each edge where ValidD is loaded with 1. It wraps to 0.
- Reset values (asynchronous on rst_n=0):
  - PCF = RESET_PC, state = BOOT.
  - PCD = 0, PCPlus4D = 0, ValidD = 0, FaultD = 0, FetchCount = 0.
  - InstrD = NOP, ImemEn = 0.
- Reset mid-operation discards all in-flight state within the same cycle.

## Timing
- Fetch latency is 1 cycle: issue at edge k with PCF=A gives InstrD=mem[A>>2], PCD=A, ValidD=1 after edge k.
- After reset release: edge 1 is BOOT -> RUN; edge 2 issues RESET_PC; first ValidD=1 follows edge 2.
- Redirect:
  - PCSrcE=1 during cycle k gives ValidD=0 after edge k.
  - The target instruction is valid after edge k+1.
  - Flushing the instruction already in decode is the hazard unit's job, via FlushD.
- Simultaneous events:
  - PCSrcE with StallF: the redirect wins and PCF loads the target.
  - PCSrcE with HaltF in RUN: the redirect wins and the state stays RUN.
- ImemEn=0 whenever StallD=1, so ImemRdata and InstrD stay stable across decode stalls.

## Test plan
- Reset release with RESET_PC=0 and mem[0..3]=I0..I3: ValidD=0 for 2 cycles, then InstrD=I0,I1,I2,I3 with PCD=0,4,8,12, ImemEn=1. FetchCount reaches 4.
- StallF=StallD=1 for 3 cycles while InstrD=I1: InstrD, PCD=4 and ValidD=1 hold, ImemEn=0. After release I2 follows with no gap and no duplicate.
- PCSrcE=1 with PCTargetE=0x40 while fetching 0x8: next ValidD=0, then PCD=0x40 with InstrD=mem[16], and FetchCount does not count the bubble.
- Redirect to 0x42, then to 0x80 (with IMEM_ADDR_WIDTH=5): FaultD=01 with InstrD=NOP and ValidD=1, then FaultD=10 with InstrD=NOP.
- HaltF=1 in RUN: ValidD=0 and ImemEn=0 from the next cycle. PCSrcE=1 with target 0x10 then resumes with PCD=0x10. FlushD with StallD forces ValidD=0.
- rst_n pulsed low mid-stream, asynchronous between edges: outputs immediately take their reset values, and the reset-release sequence repeats from RESET_PC.
